alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage block for the single-cycle RISC-V datapath.
//  Merges ALU-control decode (ALUOp + funct3), the 32-bit ALU with zero flag,
//  and the two PC adders (pc+4 and pc+imm).
//  All results are registered: one-cycle latency to the register-write, branch-mux and data-memory logic.
// PARAMETERS
//  WIDTH   32  datapath width in bits (operands, results, PC)
//  PC_INC  4   constant added to pc for the sequential next-PC
// PORTS
//  clk          in   1      rising-edge clock, only clock
//  reset        in   1      synchronous, active-low reset (asserted when 0, sampled on clk rise)
//  in_valid     in   1      operands/controls valid this cycle
//  alu_op       in   3      ALUOp from main control
//  funct3       in   3      instruction[14:12]
//  op_a         in   WIDTH  ALU operand A (readData1)
//  op_b         in   WIDTH  ALU operand B (readData2 or immediate, selected upstream)
//  pc           in   WIDTH  current PC
//  imm          in   WIDTH  sign-extended immediate
//  out_valid    out  1      registered in_valid
//  alu_ctrl     out  4      registered decoded ALU control code
//  alu_result   out  WIDTH  registered ALU result
//  zero         out  1      registered (alu_result == 0)
//  pc_plus4     out  WIDTH  registered pc + PC_INC
//  branch_tgt   out  WIDTH  registered pc + imm
// BEHAVIOUR
//  - Reset: on clk rise with reset==0, all outputs = 0 (out_valid=0, zero=0); reset wins over in_valid.
//  - Latency: outputs reflect inputs sampled on the previous clk rise; one new op per cycle, no stall.
//  - in_valid==0: out_valid<=0 on the next clk rise; data outputs hold their previous values.
//  - ALUOp decode:
//    - 000 -> ADD (load/store)
//    - 001 -> SUB (branch compare)
//    - 010 -> decode funct3
//    - 011 -> PASSB
//    - 1xx -> ADD (reserved)
//  - funct3 decode (ALUOp=010):
//    - 000 ADD, 001 SLL, 010 SLT, 011 SLTU
//    - 100 XOR, 101 SRL, 110 OR, 111 AND
//  - alu_ctrl codes:
//    - AND=0000, OR=0001, ADD=0010, XOR=0011
//    - SLL=0100, SRL=0101, SUB=0110, SLT=0111
//    - SLTU=1000, PASSB=1001
//    - any other code -> result 0
//  - Arithmetic: ADD/SUB and both PC adders wrap modulo 2^WIDTH; no overflow flag.
//  - Comparisons: SLT is signed, SLTU unsigned; result 1 or 0, zero-extended.
//  - Shifts: shift amount = op_b[4:0]; SRL is logical (zero fill).
//  - zero is computed from the same-cycle result and registered with it.
// TESTING
//  1. reset=0 with in_valid=1, op_a=5 -> after clk all outputs 0; after release, next op valid 1 cycle later.
//  2. alu_op=000, op_a=0xFFFFFFFF, op_b=1 -> alu_result=0, zero=1, alu_ctrl=0010.
//  3. alu_op=001, op_a=7, op_b=7 -> zero=1; op_b=8 -> alu_result=0xFFFFFFFF, zero=0.
//  4. alu_op=010: funct3=010 with a=-1,b=1 -> 1; funct3=011 same operands -> 0; funct3=101 with a=0x80000000,b=31 -> 1.
//  5. pc=0x100, imm=0xFFFFFFF8 -> pc_plus4=0x104, branch_tgt=0xF8.
//  6. Back-to-back ops on consecutive cycles, then in_valid=0 -> each result appears exactly 1 cycle later; out_valid drops, data holds.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute stage of the single-cycle RISC-V datapath. It decodes the ALU
//   control code from ALUOp/funct3, runs the ALU, and forms both next-PC
//   candidates (pc+PC_INC and pc+imm). Every output is registered, so the
//   results show up one clock after the operands were presented.
//
// Handshake: valid-only, no backpressure. A beat is accepted on every rising
//   edge where in_valid=1, and its results appear with out_valid=1 on the
//   following edge. When in_valid=0, out_valid drops and the data outputs keep
//   their last values.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   in_valid          operands/controls valid this cycle
//   alu_op, funct3    ALUOp from main control, instruction[14:12]
//   op_a, op_b        ALU operands
//   pc, imm           current PC, sign-extended immediate
//   out_valid         registered in_valid
//   alu_ctrl          registered decoded ALU control code
//   alu_result, zero  registered ALU result and (result == 0)
//   pc_plus4          registered pc + PC_INC
//   branch_tgt        registered pc + imm
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter int PC_INC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_tgt
);

    localparam logic [3:0] CTRL_AND   = 4'b0000;
    localparam logic [3:0] CTRL_OR    = 4'b0001;
    localparam logic [3:0] CTRL_ADD   = 4'b0010;
    localparam logic [3:0] CTRL_XOR   = 4'b0011;
    localparam logic [3:0] CTRL_SLL   = 4'b0100;
    localparam logic [3:0] CTRL_SRL   = 4'b0101;
    localparam logic [3:0] CTRL_SUB   = 4'b0110;
    localparam logic [3:0] CTRL_SLT   = 4'b0111;
    localparam logic [3:0] CTRL_SLTU  = 4'b1000;
    localparam logic [3:0] CTRL_PASSB = 4'b1001;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(PC_INC);

    logic [3:0]       ctrl_d;
    logic [WIDTH-1:0] result_d;
    logic [4:0]       shamt;

    // ALU control decode. ALUOp values 1xx are reserved and fall back to ADD.
    always_comb begin
        ctrl_d = CTRL_ADD;
        case (alu_op)
            3'b000: ctrl_d = CTRL_ADD;
            3'b001: ctrl_d = CTRL_SUB;
            3'b010: begin
                case (funct3)
                    3'b000:  ctrl_d = CTRL_ADD;
                    3'b001:  ctrl_d = CTRL_SLL;
                    3'b010:  ctrl_d = CTRL_SLT;
                    3'b011:  ctrl_d = CTRL_SLTU;
                    3'b100:  ctrl_d = CTRL_XOR;
                    3'b101:  ctrl_d = CTRL_SRL;
                    3'b110:  ctrl_d = CTRL_OR;
                    default: ctrl_d = CTRL_AND;
                endcase
            end
            3'b011:  ctrl_d = CTRL_PASSB;
            default: ctrl_d = CTRL_ADD;
        endcase
    end

    assign shamt = op_b[4:0];

    // ALU proper. Comparison results are a single bit, zero-extended.
    always_comb begin
        result_d = '0;
        case (ctrl_d)
            CTRL_AND:   result_d = op_a & op_b;
            CTRL_OR:    result_d = op_a | op_b;
            CTRL_ADD:   result_d = op_a + op_b;
            CTRL_XOR:   result_d = op_a ^ op_b;
            CTRL_SLL:   result_d = op_a << shamt;
            CTRL_SRL:   result_d = op_a >> shamt;
            CTRL_SUB:   result_d = op_a - op_b;
            CTRL_SLT:   result_d = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            CTRL_SLTU:  result_d = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            CTRL_PASSB: result_d = op_b;
            default:    result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            alu_ctrl   <= '0;
            alu_result <= '0;
            zero       <= 1'b0;
            pc_plus4   <= '0;
            branch_tgt <= '0;
        end else begin
            out_valid <= in_valid;
            // Data registers only load on a valid beat so idle cycles hold.
            if (in_valid) begin
                alu_ctrl   <= ctrl_d;
                alu_result <= result_d;
                zero       <= (result_d == '0);
                pc_plus4   <= pc + PC_STEP;
                branch_tgt <= pc + imm;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    // Expected record: {out_valid, alu_ctrl, alu_result, zero, pc_plus4, branch_tgt}
    localparam int EW = 1 + 4 + 32 + 1 + 32 + 32;
    localparam int HW = EW - 1;

    typedef enum {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND, M_PASSB} mnem_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;

    logic [EW-1:0] exp_q[$];
    logic [HW-1:0] hold_model = '0;
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    int n_checks = 0;
    int n_fail = 0;

    assign got = {out_valid, alu_ctrl, alu_result, zero, pc_plus4, branch_tgt};

    alu_exec_unit #(.WIDTH(32), .PC_INC(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .alu_op(alu_op), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .pc(pc), .imm(imm), .out_valid(out_valid), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .zero(zero), .pc_plus4(pc_plus4),
        .branch_tgt(branch_tgt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic mnem_t ref_mnem(input logic [2:0] op, input logic [2:0] f3);
        mnem_t f3_map[8] = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
        if (op >= 3'd4) return M_ADD;
        if (op == 3'd0) return M_ADD;
        if (op == 3'd1) return M_SUB;
        if (op == 3'd3) return M_PASSB;
        return f3_map[f3];
    endfunction

    function automatic logic [3:0] ref_code(input mnem_t m);
        case (m)
            M_AND:   return 4'd0;
            M_OR:    return 4'd1;
            M_ADD:   return 4'd2;
            M_XOR:   return 4'd3;
            M_SLL:   return 4'd4;
            M_SRL:   return 4'd5;
            M_SUB:   return 4'd6;
            M_SLT:   return 4'd7;
            M_SLTU:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input mnem_t m, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint pw = longint'(1) << b[4:0];
        longint r;
        case (m)
            M_ADD:   r = ua + ub;
            M_SUB:   r = ua - ub + (longint'(1) << 32);
            M_SLL:   r = ua * pw;
            M_SRL:   r = ua / pw;
            M_SLT:   r = (int'(a) < int'(b)) ? 1 : 0;
            M_SLTU:  r = (ua < ub) ? 1 : 0;
            M_XOR:   r = longint'(a ^ b);
            M_OR:    r = longint'(a | b);
            M_AND:   r = longint'(a & b);
            default: r = ub;
        endcase
        return r[31:0];
    endfunction

    // ---------------- driver ----------------
    // Applies one beat to the DUT and queues what should appear after the next edge.
    task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i);
        mnem_t m;
        logic [31:0] r;
        in_valid = v; alu_op = op; funct3 = f3; op_a = a; op_b = b; pc = p; imm = i;
        m = ref_mnem(op, f3);
        r = ref_result(m, a, b);
        if (!reset) begin
            hold_model = '0;
            exp_q.push_back('0);
        end else if (v) begin
            hold_model = {ref_code(m), r, (r == 32'd0), p + 32'd4, p + i};
            exp_q.push_back({1'b1, hold_model});
        end else begin
            exp_q.push_back({1'b0, hold_model});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 3'b000, 3'b000, 32'd5, 32'd0, 32'd0, 32'd0);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL reset_clear got=%h exp=%h", got, e); end
        end
        reset = 1'b1;
        drive(1'b1, 3'b000, 3'b000, 32'd5, 32'd3, 32'h10, 32'h20);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", got, e); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_release_valid got=%b exp=1", out_valid); end
        // Reset must also win over a valid beat once outputs are non-zero.
        reset = 1'b0;
        drive(1'b1, 3'b001, 3'b000, 32'd9, 32'd1, 32'h40, 32'h8);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_over_valid got=%h exp=%h", got, e); end
        n_checks++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_all_zero got=%h exp=0", got); end
        reset = 1'b1;
    endtask

    task automatic test_add_wrap();
        drive(1'b1, 3'b000, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL add_wrap got=%h exp=%h", got, e); end
        n_checks++;
        if (alu_result !== 32'd0 || zero !== 1'b1 || alu_ctrl !== 4'b0010) begin
            n_fail++;
            $display("FAIL add_wrap_fields got=%h/%b/%b exp=0/1/0010", alu_result, zero, alu_ctrl);
        end
    endtask

    task automatic test_sub_branch();
        drive(1'b1, 3'b001, 3'b000, 32'd7, 32'd7, 32'h0, 32'h0);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || zero !== 1'b1 || alu_ctrl !== 4'b0110) begin
            n_fail++; $display("FAIL sub_equal got=%h exp=%h", got, e);
        end
        drive(1'b1, 3'b001, 3'b000, 32'd7, 32'd8, 32'h0, 32'h0);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || alu_result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
            n_fail++; $display("FAIL sub_neg got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_funct3();
        drive(1'b1, 3'b010, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || alu_result !== 32'd1) begin n_fail++; $display("FAIL slt_signed got=%h exp=%h", got, e); end
        drive(1'b1, 3'b010, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || alu_result !== 32'd0) begin n_fail++; $display("FAIL sltu_unsigned got=%h exp=%h", got, e); end
        drive(1'b1, 3'b010, 3'b101, 32'h8000_0000, 32'd31, 32'h0, 32'h0);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || alu_result !== 32'd1) begin n_fail++; $display("FAIL srl_logical got=%h exp=%h", got, e); end
        // Walk all eight funct3 codes plus PASSB and a reserved ALUOp.
        for (int f = 0; f < 10; f++) begin
            logic [2:0] op;
            op = (f < 8) ? 3'b010 : ((f == 8) ? 3'b011 : 3'b110);
            drive(1'b1, op, 3'(f), $urandom, $urandom, $urandom, $urandom);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL decode_sweep_%0d got=%h exp=%h", f, got, e); end
        end
    endtask

    task automatic test_pc_adders();
        drive(1'b1, 3'b000, 3'b000, 32'd1, 32'd2, 32'h100, 32'hFFFF_FFF8);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || pc_plus4 !== 32'h104 || branch_tgt !== 32'hF8) begin
            n_fail++; $display("FAIL pc_adders got=%h/%h exp=104/f8", pc_plus4, branch_tgt);
        end
        drive(1'b1, 3'b000, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || pc_plus4 !== 32'h0 || branch_tgt !== 32'h4) begin
            n_fail++; $display("FAIL pc_wrap got=%h/%h exp=0/4", pc_plus4, branch_tgt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] last_res;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom, 32'($urandom_range(0, 40)), $urandom, $urandom);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL b2b_%0d got=%h exp=%h", k, got, e); end
        end
        last_res = e[96:65];
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom, $urandom);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL idle_hold_%0d got=%h exp=%h", k, got, e); end
            n_checks++;
            if (out_valid !== 1'b0 || alu_result !== last_res) begin
                n_fail++; $display("FAIL idle_fields_%0d got=%b/%h exp=0/%h", k, out_valid, alu_result, last_res);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = 32'($urandom_range(0, 63));
                2: b = ~a + 32'd1;
                default: b = $urandom;
            endcase
            reset = ($urandom_range(0, 49) != 0);
            drive(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  a, b, $urandom, $urandom);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL random_%0d got=%h exp=%h", k, got, e); end
        end
        reset = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add_wrap();
        test_sub_branch();
        test_funct3();
        test_pc_adders();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
